// File: rtl/signal_product_averager.sv
// Three-stage pipeline: select and multiply, scale by 9/8 or 3/8, then a
// DEPTH-sample moving average kept as a running sum over a circular buffer.
module signal_product_averager #(
    parameter int W          = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           in_valid,
    input  logic [W-1:0]   D1,
    input  logic [W-1:0]   D2,
    input  logic [W-1:0]   D3,
    input  logic [W-1:0]   D4,
    input  logic           Select,
    output logic           out_valid,
    output logic [2*W:0]   MPavg,
    output logic           warm
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PW    = 2 * W;
    localparam int SW    = 2 * W + 1;
    localparam int SUMW  = SW + LOG2_DEPTH;
    localparam int CW    = LOG2_DEPTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // 9*P or 3*P at full precision (2W+4 bits), truncated only by the final >>3.
    function automatic logic [SW-1:0] scale_product(input logic [PW-1:0] p, input logic sel);
        logic [PW+3:0] pe;
        logic [PW+3:0] wide;
        pe   = {4'b0000, p};
        wide = sel ? (pe + (pe << 1)) : (pe + (pe << 3));
        return wide[PW+3:3];
    endfunction

    logic              vld_p1;
    logic              sel_p1;
    logic [PW-1:0]     p_p1;
    logic              vld_p2;
    logic [SW-1:0]     s_p2;

    logic [SW-1:0]         win_buf [DEPTH];
    logic [SUMW-1:0]       sum;
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [CW-1:0]         count;

    logic [SUMW-1:0]       sum_next;
    logic [CW-1:0]         count_next;

    // ---- stage 1: operand select and multiply ----
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        sel_p1 <= Select;
        p_p1   <= Select ? ({{W{1'b0}}, D3} * {{W{1'b0}}, D4})
                         : ({{W{1'b0}}, D1} * {{W{1'b0}}, D2});
    end

    // ---- stage 2: scaling ----
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        s_p2 <= scale_product(p_p1, sel_p1);
    end

    // ---- stage 3: window update ----
    // Oldest slot is retired and the newest added in one expression, so the
    // running sum never passes through an intermediate value.
    always_comb begin
        sum_next   = sum - SUMW'(win_buf[wr_ptr]) + SUMW'(s_p2);
        count_next = (count == DEPTH_C) ? count : count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_buf[i] <= '0;
            end
            sum       <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            warm      <= 1'b0;
            out_valid <= 1'b0;
            MPavg     <= '0;
        end else if (vld_p2) begin
            win_buf[wr_ptr] <= s_p2;
            sum             <= sum_next;
            wr_ptr          <= wr_ptr + 1'b1;
            count           <= count_next;
            warm            <= (count_next == DEPTH_C);
            out_valid       <= 1'b1;
            MPavg           <= sum_next[SUMW-1:LOG2_DEPTH];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_signal_product_averager.sv
// Randomized and directed bench for signal_product_averager against a
// queue-based moving-average model.
module tb_signal_product_averager;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst, clear, in_valid, Select;
    logic [W-1:0]   D1, D2, D3, D4;
    logic           out_valid, warm;
    logic [2*W:0]   MPavg;

    always #5 clk = ~clk;

    signal_product_averager #(.W(W), .LOG2_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .D1(D1), .D2(D2), .D3(D3), .D4(D4), .Select(Select),
        .out_valid(out_valid), .MPavg(MPavg), .warm(warm)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit     hv [8192];
    bit     hk [8192];
    longint hs [8192];

    longint       win [$];
    int           nsamp = 0;
    logic         exp_ov = 1'b0;
    logic         exp_warm = 1'b0;
    logic [2*W:0] exp_avg = '0;

    function automatic longint s_of(bit sel, longint a, longint b, longint c, longint d);
        longint p;
        p = sel ? c * d : a * b;
        return sel ? (3 * p) / 8 : (9 * p) / 8;
    endfunction

    // Apply one cycle of inputs, advance past the edge, update the model.
    // A sample shown in cycle k appears at the third edge unless a clear or
    // reset occurs in cycles k..k+2.
    task automatic tick(bit v, bit sel, logic [W-1:0] a, logic [W-1:0] b,
                        logic [W-1:0] c, logic [W-1:0] d, bit clr, bit r);
        longint sum;
        longint q;
        in_valid = v; Select = sel; D1 = a; D2 = b; D3 = c; D4 = d;
        clear = clr; rst = r;
        hv[cyc] = v;
        hk[cyc] = clr | r;
        hs[cyc] = s_of(sel, a, b, c, d);
        @(posedge clk);
        #1;
        if (hk[cyc]) begin
            win.delete();
            nsamp = 0; exp_ov = 1'b0; exp_avg = '0; exp_warm = 1'b0;
        end else if (cyc >= 2 && hv[cyc-2] && !hk[cyc-2] && !hk[cyc-1]) begin
            win.push_back(hs[cyc-2]);
            if (win.size() > 8) void'(win.pop_front());
            sum = 0;
            foreach (win[i]) sum += win[i];
            q = sum / 8;
            exp_avg = q[2*W:0];
            nsamp++;
            exp_warm = (nsamp >= 8);
            exp_ov = 1'b1;
        end else begin
            exp_ov = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(0, 0, '0, '0, '0, '0, 0, 0);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            tick(1, i[0], 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 1);
            checks++;
            if (out_valid !== 1'b0 || MPavg !== '0 || warm !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc=%0d out_valid=%b MPavg=%h warm=%b required 0/0/0",
                         cyc, out_valid, MPavg, warm);
            end
        end
    endtask

    task automatic test_single;
        tick(0, 0, '0, '0, '0, '0, 1, 0);
        tick(1, 0, 16'h0010, 16'h0020, '0, '0, 0, 0);
        idle(2);
        checks++;
        if (out_valid !== 1'b1 || MPavg !== 33'd72 || warm !== 1'b0) begin
            errors++;
            $display("FAIL single out_valid=%b MPavg=%0d warm=%b required 1/72/0",
                     out_valid, MPavg, warm);
        end
        idle(2);
        checks++;
        if (out_valid !== exp_ov || MPavg !== exp_avg || warm !== exp_warm) begin
            errors++;
            $display("FAIL single_after out_valid=%b/%b MPavg=%h/%h warm=%b/%b",
                     out_valid, exp_ov, MPavg, exp_avg, warm, exp_warm);
        end
    endtask

    task automatic test_fill;
        int steps [8] = '{8, 16, 24, 33, 41, 49, 57, 66};
        int k = 0;
        tick(0, 0, '0, '0, '0, '0, 1, 0);
        for (int i = 0; i < 11; i++) begin
            if (i < 8) tick(1, 1, '0, '0, 16'h0008, 16'h0016, 0, 0);
            else       idle(1);
            if (out_valid === 1'b1 && k < 8) begin
                checks++;
                if (MPavg !== 33'(steps[k]) || warm !== (k == 7)) begin
                    errors++;
                    $display("FAIL fill_step%0d MPavg=%0d warm=%b required %0d/%b",
                             k, MPavg, warm, steps[k], (k == 7));
                end
                k++;
            end
        end
        checks++;
        if (k !== 8) begin
            errors++;
            $display("FAIL fill_count pulses=%0d required 8", k);
        end
    endtask

    task automatic test_wrap;
        logic [2*W:0] prev;
        int k = 0;
        prev = MPavg;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) tick(1, 0, 16'h0010, 16'h0020, '0, '0, 0, 0);
            else       idle(1);
            checks++;
            if (out_valid !== exp_ov || MPavg !== exp_avg || MPavg < prev) begin
                errors++;
                $display("FAIL wrap cyc=%0d out_valid=%b/%b MPavg=%0d/%0d prev=%0d",
                         cyc, out_valid, exp_ov, MPavg, exp_avg, prev);
            end
            if (out_valid === 1'b1) k++;
            prev = MPavg;
        end
        checks++;
        if (MPavg !== 33'd576 || k !== 8 || warm !== 1'b1) begin
            errors++;
            $display("FAIL wrap_final MPavg=%0d pulses=%0d warm=%b required 576/8/1", MPavg, k, warm);
        end
    endtask

    task automatic test_full_scale;
        tick(0, 0, '0, '0, '0, '0, 1, 0);
        for (int i = 0; i < 8; i++) tick(1, 0, 16'hFFFF, 16'hFFFF, '0, '0, 0, 0);
        idle(2);
        checks++;
        if (MPavg !== 33'h11FFDC001 || warm !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_scale MPavg=%h warm=%b out_valid=%b required 11ffdc001/1/1",
                     MPavg, warm, out_valid);
        end
    endtask

    task automatic test_bubbles;
        bit pat [4] = '{1, 0, 0, 1};
        int pulses = 0;
        tick(0, 0, '0, '0, '0, '0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) tick(pat[i], 0, 16'h0123, 16'h0042, '0, '0, 0, 0);
            else       idle(1);
            checks++;
            if (out_valid !== exp_ov || MPavg !== exp_avg || warm !== exp_warm) begin
                errors++;
                $display("FAIL bubbles cyc=%0d out_valid=%b/%b MPavg=%h/%h warm=%b/%b",
                         cyc, out_valid, exp_ov, MPavg, exp_avg, warm, exp_warm);
            end
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL bubbles_count pulses=%0d required 2", pulses);
        end
    endtask

    task automatic test_flush;
        int pulses = 0;
        tick(1, 0, 16'h1111, 16'h2222, '0, '0, 0, 0);
        tick(1, 1, '0, '0, 16'h3333, 16'h4444, 0, 0);
        tick(1, 0, 16'h5555, 16'h6666, '0, '0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (out_valid !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0 || MPavg !== '0 || warm !== 1'b0) begin
            errors++;
            $display("FAIL flush pulses=%0d MPavg=%h warm=%b required 0/0/0", pulses, MPavg, warm);
        end
        tick(1, 0, 16'h0010, 16'h0020, '0, '0, 0, 0);
        idle(2);
        checks++;
        if (out_valid !== 1'b1 || MPavg !== 33'd72 || warm !== 1'b0) begin
            errors++;
            $display("FAIL flush_next out_valid=%b MPavg=%0d warm=%b required 1/72/0",
                     out_valid, MPavg, warm);
        end
    endtask

    task automatic test_reset_mid;
        tick(1, 0, 16'hABCD, 16'h1234, '0, '0, 0, 0);
        tick(1, 1, '0, '0, 16'h0F0F, 16'hF0F0, 0, 0);
        tick(0, 0, '0, '0, '0, '0, 0, 1);
        idle(3);
        checks++;
        if (out_valid !== 1'b0 || MPavg !== '0 || warm !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid out_valid=%b MPavg=%h warm=%b required 0/0/0",
                     out_valid, MPavg, warm);
        end
        tick(1, 0, 16'h0010, 16'h0020, '0, '0, 0, 0);
        idle(2);
        checks++;
        if (out_valid !== 1'b1 || MPavg !== 33'd72) begin
            errors++;
            $display("FAIL reset_mid_next out_valid=%b MPavg=%0d required 1/72", out_valid, MPavg);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 90) == 0));
            checks++;
            if (out_valid !== exp_ov || MPavg !== exp_avg || warm !== exp_warm) begin
                errors++;
                $display("FAIL random cyc=%0d out_valid=%b/%b MPavg=%h/%h warm=%b/%b",
                         cyc, out_valid, exp_ov, MPavg, exp_avg, warm, exp_warm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_full_scale();
        test_bubbles();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
